// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential ALU.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_MUL = 4'd4;
    localparam opcode_t OP_DIV = 4'd5;
    localparam opcode_t OP_SHL = 4'd6;
    localparam opcode_t OP_SHR = 4'd7;
    localparam opcode_t OP_ROL = 4'd8;
    localparam opcode_t OP_ROR = 4'd9;

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
    logic             div_q, run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   mul_sum, mul_acc, div_trial;

    assign mul_sum   = {1'b0, hi_q} + {1'b0, b_q};
    assign mul_acc   = lo_q[0] ? mul_sum : {1'b0, hi_q};
    assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (!div_trial[WIDTH]) begin
                hi_d = div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_acc[WIDTH:1];
            lo_d = {mul_acc[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = run_q && (cnt_q == CW'(WIDTH - 1));
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle ops plus iterative signed MUL/DIV with sign fix-up.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    opcode_t          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
    logic             ov_q, ov_d, dz_q, dz_d, ill_q, ill_d;

    logic             accept, is_md, eng_done, big_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sum, diff, abs_a, abs_b, eng_hi, eng_lo;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0] sc_out1;
    logic             sc_ov, sc_ill;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign is_md     = (op == OP_MUL) || (op == OP_DIV);

    assign sum       = in1 + in2;
    assign diff      = in1 - in2;
    assign amt       = in2[SHW-1:0];
    assign big_shift = |in2[WIDTH-1:SHW];
    assign rot_l     = {in1, in1} << amt;
    assign rot_r     = {in1, in1} >> amt;
    assign abs_a     = in1[WIDTH-1] ? -in1 : in1;
    assign abs_b     = in2[WIDTH-1] ? -in2 : in2;

    always_comb begin
        sc_out1 = '0;
        sc_ov   = 1'b0;
        sc_ill  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_out1 = sum;
                sc_ov   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out1 = diff;
                sc_ov   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: sc_out1 = in1 & in2;
            OP_OR:  sc_out1 = in1 | in2;
            OP_MUL, OP_DIV: sc_out1 = '0;
            OP_SHL: sc_out1 = big_shift ? '0 : (in1 << amt);
            OP_SHR: sc_out1 = big_shift ? '0 : (in1 >> amt);
            OP_ROL: sc_out1 = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR: sc_out1 = rot_r[WIDTH-1:0];
            default: sc_ill = 1'b1;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_md),
        .is_div (op == OP_DIV),
        .a      (abs_a),
        .b      (abs_b),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    // Sign fix-up of the magnitude result.
    logic               neg;
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fx_out1, fx_out2;
    logic               fx_ov, fx_dz;

    assign neg    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign prod_u = {eng_hi, eng_lo};
    assign prod_s = neg ? -prod_u : prod_u;
    assign quo_s  = neg ? -eng_lo : eng_lo;
    assign rem_s  = a_q[WIDTH-1] ? -eng_hi : eng_hi;

    always_comb begin
        fx_out1 = quo_s;
        fx_out2 = rem_s;
        fx_ov   = 1'b0;
        fx_dz   = 1'b0;
        if (op_q == OP_MUL) begin
            {fx_out2, fx_out1} = prod_s;
            fx_ov = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        end else if (b_q == '0) begin
            fx_out1 = '1;
            fx_out2 = a_q;
            fx_dz   = 1'b1;
        end else if (a_q == MinVal && b_q == '1) begin
            fx_out1 = MinVal;
            fx_out2 = '0;
            fx_ov   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    out2_d = '0;
                    dz_d   = 1'b0;
                    if (is_md) begin
                        state_d = StBusy;
                        out1_d  = '0;
                        ov_d    = 1'b0;
                        ill_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        out1_d  = sc_out1;
                        ov_d    = sc_ov;
                        ill_d   = sc_ill;
                    end
                end
            end
            StBusy: if (eng_done) state_d = StFix;
            StFix: begin
                state_d = StDone;
                out1_d  = fx_out1;
                out2_d  = fx_out2;
                ov_d    = fx_ov;
                dz_d    = fx_dz;
            end
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
            if (accept) begin
                op_q <= op;
                a_q  <= in1;
                b_q  <= in2;
            end
        end
    end

    assign out1     = out1_q;
    assign out2     = out2_q;
    assign overflow = ov_q;
    assign div_zero = dz_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [15:0] in1 = 16'd0;
    logic [15:0] in2 = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out1, out2;
    logic        overflow, div_zero, illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] o1;
        logic [15:0] o2;
        logic        ov;
        logic        dz;
        logic        il;
    } res_t;

    res_t last_exp;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    function automatic res_t model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        res_t        r;
        int          sa, sb, s, q, m;
        int unsigned ua, ub, k;
        logic [31:0] t;
        r  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = {16'd0, a};
        ub = {16'd0, b};
        k  = ub % 16;
        t  = '0;
        case (o)
            4'd0: begin s = sa + sb; t = s; r.o1 = t[15:0]; r.ov = (s > 32767) || (s < -32768); end
            4'd1: begin s = sa - sb; t = s; r.o1 = t[15:0]; r.ov = (s > 32767) || (s < -32768); end
            4'd2: r.o1 = a & b;
            4'd3: r.o1 = a | b;
            4'd4: begin
                s = sa * sb; t = s;
                r.o1 = t[15:0]; r.o2 = t[31:16];
                r.ov = (s > 32767) || (s < -32768);
            end
            4'd5: begin
                if (b == 16'd0) begin
                    r.o1 = 16'hFFFF; r.o2 = a; r.dz = 1'b1;
                end else if (sa == -32768 && sb == -1) begin
                    r.o1 = 16'h8000; r.o2 = 16'd0; r.ov = 1'b1;
                end else begin
                    q = sa / sb; m = sa % sb;
                    t = q; r.o1 = t[15:0];
                    t = m; r.o2 = t[15:0];
                end
            end
            4'd6: begin t = ua << k; r.o1 = (ub >= 16) ? 16'd0 : t[15:0]; end
            4'd7: begin t = ua >> k; r.o1 = (ub >= 16) ? 16'd0 : t[15:0]; end
            4'd8: begin t = (ua << k) | (ua >> (16 - k)); r.o1 = t[15:0]; end
            4'd9: begin t = (ua >> k) | (ua << (16 - k)); r.o1 = t[15:0]; end
            default: r.il = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic issue_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        res_t  e;
        int    lat;
        int    exp_lat;
        string tag;
        e       = model(o, a, b);
        exp_lat = (o == 4'd4 || o == 4'd5) ? 18 : 1;
        tag     = $sformatf("op%0d %h,%h", o, a, b);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; op = 4'($urandom); in1 = 16'($urandom); in2 = 16'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " out2:out1"}, {out2, out1}, {e.o2, e.o1});
        chk({tag, " ov/dz/il"}, {29'd0, overflow, div_zero, illegal}, {29'd0, e.ov, e.dz, e.il});
        last_exp = e;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release out_valid", {31'd0, out_valid}, 32'd0);
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        issue_op(o, a, b);
        release_result();
    endtask

    initial begin
        logic [3:0]  ro;
        logic [15:0] ra, rb;
        bit          seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset outputs", {out2, out1}, 32'd0);
        chk("reset flags", {29'd0, overflow, div_zero, illegal}, 32'd0);

        run_op(4'd0, 16'h7FFF, 16'h0001);
        run_op(4'd1, 16'h0005, 16'h0007);
        run_op(4'd4, 16'hFFFD, 16'h0005);
        run_op(4'd4, 16'h0100, 16'h0100);
        run_op(4'd5, 16'hFFF9, 16'h0002);
        run_op(4'd5, 16'd100, 16'h0000);
        run_op(4'd5, 16'h8000, 16'hFFFF);
        run_op(4'd9, 16'h0001, 16'd1);
        run_op(4'd8, 16'h8001, 16'd17);
        run_op(4'd6, 16'h0001, 16'd20);
        run_op(4'd8, 16'h1234, 16'd0);
        run_op(4'd12, 16'h1234, 16'h5678);

        // Backpressure: result must hold and new requests must be ignored.
        issue_op(4'd3, 16'hA050, 16'h0F0F);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op = 4'd1; in1 = 16'($urandom); in2 = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("bp out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp outputs", {out2, out1}, {last_exp.o2, last_exp.o1});
        end
        in_valid = 1'b0;
        release_result();

        // Reset in the middle of a multiply discards it.
        in_valid = 1'b1; op = 4'd4; in1 = 16'h1234; in2 = 16'h0777;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort outputs", {out2, out1}, 32'd0);
        chk("abort flags", {29'd0, overflow, div_zero, illegal}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort no result", {31'd0, seen}, 32'd0);
        run_op(4'd0, 16'd2, 16'd3);

        for (int i = 0; i < 50; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((ro == 4'd6 || ro == 4'd7) && $urandom_range(0, 1) == 1) rb = 16'($urandom_range(0, 20));
            if (ro == 4'd5 && $urandom_range(0, 5) == 0) rb = 16'd0;
            if (ro == 4'd4 && $urandom_range(0, 1) == 1) begin
                ra = 16'($signed(8'($urandom)));
                rb = 16'($signed(8'($urandom)));
            end
            run_op(ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
